// File: rtl/serial_parity_checker.sv
// Serial parity checker: accumulates XOR parity over FRAME_LEN data bits, compares
// it with the trailing parity bit and presents the result through a valid/ack handshake.
module serial_parity_checker #(
    parameter int FRAME_LEN  = 3,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_in,
    input  logic       bit_valid,
    output logic       bit_ready,
    output logic       parity_out,
    output logic       parity_valid,
    input  logic       parity_ack,
    output logic       par_err,
    output logic [7:0] frame_cnt,
    output logic [7:0] err_cnt
);

    localparam int CNT_W = $clog2(FRAME_LEN) + 1;
    localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        DATA = 2'd0,
        PAR  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             acc_q, acc_d;
    logic             parity_out_q, parity_out_d;
    logic             par_err_q, par_err_d;
    logic             parity_valid_q, parity_valid_d;
    logic             bit_ready_q, bit_ready_d;
    logic [7:0]       frame_cnt_q, frame_cnt_d;
    logic [7:0]       err_cnt_q, err_cnt_d;
    logic             frame_err;

    assign frame_err = (acc_q ^ bit_in) != ODD_PARITY;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        acc_d          = acc_q;
        parity_out_d   = parity_out_q;
        par_err_d      = par_err_q;
        frame_cnt_d    = frame_cnt_q;
        err_cnt_d      = err_cnt_q;

        unique case (state_q)
            DATA: begin
                if (bit_valid) begin
                    acc_d = acc_q ^ bit_in;
                    if (cnt_q == LAST_DATA) begin
                        cnt_d   = '0;
                        state_d = PAR;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            PAR: begin
                if (bit_valid) begin
                    parity_out_d = acc_q ^ ODD_PARITY;
                    par_err_d    = frame_err;
                    frame_cnt_d  = frame_cnt_q + 8'd1;
                    if (frame_err && (err_cnt_q != 8'hFF)) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (parity_ack) begin
                    acc_d   = 1'b0;
                    state_d = DATA;
                end
            end
            default: begin
                state_d = DATA;
            end
        endcase

        // Handshake outputs are registered from the next state so they line up with it.
        bit_ready_d    = (state_d != HOLD);
        parity_valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= DATA;
            cnt_q          <= '0;
            acc_q          <= 1'b0;
            parity_out_q   <= 1'b0;
            par_err_q      <= 1'b0;
            parity_valid_q <= 1'b0;
            bit_ready_q    <= 1'b1;
            frame_cnt_q    <= 8'd0;
            err_cnt_q      <= 8'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            acc_q          <= acc_d;
            parity_out_q   <= parity_out_d;
            par_err_q      <= par_err_d;
            parity_valid_q <= parity_valid_d;
            bit_ready_q    <= bit_ready_d;
            frame_cnt_q    <= frame_cnt_d;
            err_cnt_q      <= err_cnt_d;
        end
    end

    assign bit_ready    = bit_ready_q;
    assign parity_valid = parity_valid_q;
    assign parity_out   = parity_out_q;
    assign par_err      = par_err_q;
    assign frame_cnt    = frame_cnt_q;
    assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_serial_parity_checker.sv
// Bench for serial_parity_checker: an even-parity and an odd-parity instance share one
// stimulus stream; expected results go through a scoreboard queue.
module tb_serial_parity_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       bit_in;
    logic       bit_valid;
    logic       parity_ack;

    logic       bit_ready_e, parity_out_e, parity_valid_e, par_err_e;
    logic [7:0] frame_cnt_e, err_cnt_e;
    logic       bit_ready_o, parity_out_o, parity_valid_o, par_err_o;
    logic [7:0] frame_cnt_o, err_cnt_o;

    always #5 clk = ~clk;

    serial_parity_checker #(.FRAME_LEN(3), .ODD_PARITY(1'b0)) dut_even (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(bit_ready_e), .parity_out(parity_out_e), .parity_valid(parity_valid_e),
        .parity_ack(parity_ack), .par_err(par_err_e), .frame_cnt(frame_cnt_e), .err_cnt(err_cnt_e)
    );

    serial_parity_checker #(.FRAME_LEN(3), .ODD_PARITY(1'b1)) dut_odd (
        .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(bit_ready_o), .parity_out(parity_out_o), .parity_valid(parity_valid_o),
        .parity_ack(parity_ack), .par_err(par_err_o), .frame_cnt(frame_cnt_o), .err_cnt(err_cnt_o)
    );

    typedef struct {
        logic [2:0] data;
        logic       par;
        logic       pout_e;
        logic       err_e;
        logic       pout_o;
        logic       err_o;
    } vec_t;

    typedef struct {
        logic       pout_e;
        logic       err_e;
        logic       pout_o;
        logic       err_o;
        logic [7:0] fc;
        logic [7:0] ec_e;
        logic [7:0] ec_o;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] model_fc, model_ec_e, model_ec_o;
    int         n_checks = 0;
    int         n_fail   = 0;

    task automatic checkVal(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; every task starts and ends there.
    task automatic sendBit(input logic b);
        int guard = 0;
        bit_in    = b;
        bit_valid = 1'b1;
        while (!bit_ready_e && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) checkVal("bit_ready_timeout", 8'd0, 8'd1);
        @(posedge clk); #1;
        bit_valid = 1'b0;
    endtask

    task automatic pushExpect(input vec_t v);
        exp_t e;
        model_fc = model_fc + 8'd1;
        if (v.err_e && model_ec_e != 8'hFF) model_ec_e = model_ec_e + 8'd1;
        if (v.err_o && model_ec_o != 8'hFF) model_ec_o = model_ec_o + 8'd1;
        e.pout_e = v.pout_e;
        e.err_e  = v.err_e;
        e.pout_o = v.pout_o;
        e.err_o  = v.err_o;
        e.fc     = model_fc;
        e.ec_e   = model_ec_e;
        e.ec_o   = model_ec_o;
        sb.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        int   waited = 0;
        while (!parity_valid_e && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        checkVal("result_latency", 8'(waited), 8'd0);
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL scoreboard: got a result, expected none queued");
        end else begin
            e = sb.pop_front();
            checkVal("parity_valid_e", parity_valid_e, 8'd1);
            checkVal("parity_valid_o", parity_valid_o, 8'd1);
            checkVal("bit_ready_hold", bit_ready_e, 8'd0);
            checkVal("parity_out_e", parity_out_e, e.pout_e);
            checkVal("par_err_e", par_err_e, e.err_e);
            checkVal("parity_out_o", parity_out_o, e.pout_o);
            checkVal("par_err_o", par_err_o, e.err_o);
            checkVal("frame_cnt_e", frame_cnt_e, e.fc);
            checkVal("frame_cnt_o", frame_cnt_o, e.fc);
            checkVal("err_cnt_e", err_cnt_e, e.ec_e);
            checkVal("err_cnt_o", err_cnt_o, e.ec_o);
        end
    endtask

    task automatic ackResult();
        parity_ack = 1'b1;
        @(posedge clk); #1;
        parity_ack = 1'b0;
        checkVal("ready_after_ack", bit_ready_e, 8'd1);
        checkVal("valid_after_ack", parity_valid_e, 8'd0);
    endtask

    task automatic applyStimulus(input vec_t v, input bit do_ack);
        pushExpect(v);
        for (int i = 2; i >= 0; i--) sendBit(v.data[i]);
        sendBit(v.par);
        checkOutput();
        if (do_ack) ackResult();
    endtask

    task automatic doReset(input int cycles);
        rst       = 1'b1;
        bit_valid = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        model_fc   = 8'd0;
        model_ec_e = 8'd0;
        model_ec_o = 8'd0;
    endtask

    task automatic checkReset(input string tag);
        checkVal({tag, "_bit_ready"}, {bit_ready_o, bit_ready_e}, 8'h3);
        checkVal({tag, "_parity_valid"}, {parity_valid_o, parity_valid_e}, 8'h0);
        checkVal({tag, "_parity_out"}, {parity_out_o, parity_out_e}, 8'h0);
        checkVal({tag, "_par_err"}, {par_err_o, par_err_e}, 8'h0);
        checkVal({tag, "_frame_cnt"}, frame_cnt_e | frame_cnt_o, 8'h0);
        checkVal({tag, "_err_cnt"}, err_cnt_e | err_cnt_o, 8'h0);
    endtask

    vec_t table_v[6];
    vec_t v_good, v_bad, v_bp, v_mid;
    bit   bp_valid[7] = '{1, 0, 0, 1, 0, 1, 1};
    bit   bp_bits[7]  = '{1, 1, 1, 1, 1, 0, 0};

    initial begin
        // data bits sent MSB first; even: pout=^data, odd: pout=~^data
        table_v[0] = '{data: 3'b101, par: 1'b0, pout_e: 1'b0, err_e: 1'b0, pout_o: 1'b1, err_o: 1'b1};
        table_v[1] = '{data: 3'b111, par: 1'b0, pout_e: 1'b1, err_e: 1'b1, pout_o: 1'b0, err_o: 1'b0};
        table_v[2] = '{data: 3'b001, par: 1'b1, pout_e: 1'b1, err_e: 1'b0, pout_o: 1'b0, err_o: 1'b1};
        table_v[3] = '{data: 3'b000, par: 1'b0, pout_e: 1'b0, err_e: 1'b0, pout_o: 1'b1, err_o: 1'b1};
        table_v[4] = '{data: 3'b110, par: 1'b1, pout_e: 1'b0, err_e: 1'b1, pout_o: 1'b1, err_o: 1'b0};
        table_v[5] = '{data: 3'b011, par: 1'b1, pout_e: 1'b0, err_e: 1'b1, pout_o: 1'b1, err_o: 1'b0};
        v_good = table_v[0];
        v_bad  = table_v[1];
        v_bp   = '{data: 3'b110, par: 1'b0, pout_e: 1'b0, err_e: 1'b0, pout_o: 1'b1, err_o: 1'b1};
        v_mid  = table_v[2];

        rst        = 1'b1;
        bit_in     = 1'b0;
        bit_valid  = 1'b0;
        parity_ack = 1'b0;

        doReset(2);
        checkReset("reset");

        foreach (table_v[i]) applyStimulus(table_v[i], 1'b1);

        // Gappy valid: only the 4th accepted bit (the parity bit) completes the frame.
        begin
            int nvalid = 0;
            pushExpect(v_bp);
            for (int i = 0; i < 7; i++) begin
                bit_valid = bp_valid[i];
                bit_in    = bp_bits[i];
                @(posedge clk); #1;
                if (bp_valid[i]) nvalid++;
                checkVal("bp_parity_valid", parity_valid_e, (nvalid == 4) ? 8'd1 : 8'd0);
            end
            bit_valid = 1'b0;
            checkOutput();
            ackResult();
        end

        // Result held while unacked; offered bits are not consumed.
        applyStimulus(v_bad, 1'b0);
        for (int i = 0; i < 5; i++) begin
            bit_valid = 1'b1;
            bit_in    = i[0];
            @(posedge clk); #1;
            checkVal("hold_bit_ready", bit_ready_e, 8'd0);
            checkVal("hold_parity_valid", parity_valid_e, 8'd1);
            checkVal("hold_parity_out", parity_out_e, v_bad.pout_e);
            checkVal("hold_par_err", par_err_e, v_bad.err_e);
            checkVal("hold_frame_cnt", frame_cnt_e, model_fc);
        end
        bit_valid = 1'b0;
        ackResult();
        applyStimulus(v_good, 1'b1);

        // Reset while holding a result, with a simultaneous ack.
        applyStimulus(v_good, 1'b0);
        parity_ack = 1'b1;
        doReset(1);
        parity_ack = 1'b0;
        checkReset("hold_reset");

        // Reset mid-frame discards the partial frame.
        applyStimulus(v_good, 1'b1);
        sendBit(1'b1);
        sendBit(1'b0);
        doReset(1);
        checkReset("mid_reset");
        applyStimulus(v_mid, 1'b1);

        // Counter boundaries from a clean start.
        doReset(1);
        for (int i = 0; i < 256; i++) applyStimulus(v_good, 1'b1);
        checkVal("frame_cnt_wrap", frame_cnt_e, 8'd0);
        checkVal("err_cnt_o_sat", err_cnt_o, 8'd255);
        for (int i = 0; i < 300; i++) applyStimulus(v_bad, 1'b1);
        checkVal("err_cnt_e_sat", err_cnt_e, 8'd255);
        checkVal("frame_cnt_after", frame_cnt_e, 8'd44);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
